hex_target_gen: RTL and testbench

HEX_TARGET_GEN -- requirements
Module: hex_target_gen

---
 rtl/hex_target_pkg.sv | 22 ++
 rtl/target_timer.sv | 36 +++
 rtl/hex_target_gen.sv | 152 +++++++++++++++
 tb/tb_hex_target_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hex_target_pkg.sv
// Shared types, widths and helpers for the hex target generator.
package hex_target_pkg;

  localparam int unsigned TARGET_W = 8;
  localparam logic [TARGET_W-1:0] CNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAW   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  // Forced value after too many rejects; skips 0x00 on wrap.
  function automatic logic [TARGET_W-1:0] fallback_next(input logic [TARGET_W-1:0] last);
    return (last == CNT_MAX) ? TARGET_W'(1) : last + TARGET_W'(1);
  endfunction

  function automatic logic [TARGET_W-1:0] sat_inc(input logic [TARGET_W-1:0] v);
    return (v == CNT_MAX) ? v : v + TARGET_W'(1);
  endfunction

endpackage

// File: rtl/target_timer.sv
// Countdown for the live target window; expire_c is high on the last ACTIVE cycle.
module target_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expire_c
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = LOAD_VAL;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_c = en_i && (count_q == '0);

endmodule

// File: rtl/hex_target_gen.sv
// Hex target generator: draws a non-zero target distinct from the last one,
// then scores hits, wrong guesses and timeouts with saturating counters.
module hex_target_gen
  import hex_target_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned MAX_TRIES      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         rnd,
  input  logic                start,
  input  logic                stop,
  input  logic [TARGET_W-1:0] guess,
  input  logic                guess_valid,
  output logic [TARGET_W-1:0] target,
  output logic                target_valid,
  output logic                hit_pulse,
  output logic                wrong_pulse,
  output logic                miss_pulse,
  output logic [TARGET_W-1:0] hit_count,
  output logic [TARGET_W-1:0] miss_count
);

  localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  state_e              state_q, state_d;
  // target_q doubles as last_target: it always holds the most recently accepted value.
  logic [TARGET_W-1:0] target_q, target_d;
  logic [TRY_W-1:0]    tries_q, tries_d;
  logic                tv_q, tv_d;
  logic                hit_q, hit_d, wrong_q, wrong_d, miss_q, miss_d;
  logic [TARGET_W-1:0] hc_q, hc_d, mc_q, mc_d;
  logic [TARGET_W-1:0] cand_c, accept_val_c;
  logic                accept_c, hit_c, expire_c;
  logic                unused_rnd_hi;

  assign cand_c        = rnd[TARGET_W-1:0];
  assign unused_rnd_hi = ^rnd[15:TARGET_W];

  target_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (accept_c),
    .en_i     (state_q == ACTIVE),
    .expire_c (expire_c)
  );

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    tries_d      = tries_q;
    tv_d         = tv_q;
    hit_d        = 1'b0;
    wrong_d      = 1'b0;
    miss_d       = 1'b0;
    hc_d         = hc_q;
    mc_d         = mc_q;
    accept_c     = 1'b0;
    accept_val_c = cand_c;
    hit_c        = 1'b0;

    if (stop) begin
      state_d = IDLE;
      tv_d    = 1'b0;
      tries_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            hc_d    = '0;
            mc_d    = '0;
            tries_d = '0;
            state_d = DRAW;
          end
        end
        DRAW: begin
          if ((cand_c != '0) && (cand_c != target_q)) begin
            accept_c = 1'b1;
          end else if (tries_q == LAST_TRY) begin
            accept_c     = 1'b1;
            accept_val_c = fallback_next(target_q);
          end else begin
            tries_d = tries_q + TRY_W'(1);
          end
          if (accept_c) begin
            target_d = accept_val_c;
            tv_d     = 1'b1;
            tries_d  = '0;
            state_d  = ACTIVE;
          end
        end
        ACTIVE: begin
          hit_c   = guess_valid && (guess == target_q);
          wrong_d = guess_valid && !hit_c;
          // A hit on the expiry cycle is scored as a hit, never a miss.
          if (hit_c) begin
            hit_d   = 1'b1;
            hc_d    = sat_inc(hc_q);
            tv_d    = 1'b0;
            state_d = DRAW;
          end else if (expire_c) begin
            miss_d  = 1'b1;
            mc_d    = sat_inc(mc_q);
            tv_d    = 1'b0;
            state_d = DRAW;
          end
        end
        default: begin
          state_d = IDLE;
          tv_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      tries_q  <= '0;
      tv_q     <= 1'b0;
      hit_q    <= 1'b0;
      wrong_q  <= 1'b0;
      miss_q   <= 1'b0;
      hc_q     <= '0;
      mc_q     <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      tries_q  <= tries_d;
      tv_q     <= tv_d;
      hit_q    <= hit_d;
      wrong_q  <= wrong_d;
      miss_q   <= miss_d;
      hc_q     <= hc_d;
      mc_q     <= mc_d;
    end
  end

  assign target       = target_q;
  assign target_valid = tv_q;
  assign hit_pulse    = hit_q;
  assign wrong_pulse  = wrong_q;
  assign miss_pulse   = miss_q;
  assign hit_count    = hc_q;
  assign miss_count   = mc_q;

endmodule

// File: tb/tb_hex_target_gen.sv
// Directed plus randomized bench for hex_target_gen against a phase/deadline reference model.
module tb_hex_target_gen;

  localparam int TMO   = 8;
  localparam int TRIES = 4;

  logic        clk, rst;
  logic [15:0] rnd;
  logic        start, stop, guess_valid;
  logic [7:0]  guess;
  logic [7:0]  target, hit_count, miss_count;
  logic        target_valid, hit_pulse, wrong_pulse, miss_pulse;

  hex_target_gen #(
    .TIMEOUT_CYCLES(TMO),
    .MAX_TRIES     (TRIES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rnd         (rnd),
    .start       (start),
    .stop        (stop),
    .guess       (guess),
    .guess_valid (guess_valid),
    .target      (target),
    .target_valid(target_valid),
    .hit_pulse   (hit_pulse),
    .wrong_pulse (wrong_pulse),
    .miss_pulse  (miss_pulse),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase 0=idle 1=draw 2=active, timeout as an absolute cycle deadline.
  int         m_phase, m_rej, cyc, deadline;
  logic [7:0] e_tgt, e_hc, e_mc;
  logic       e_tv, e_hit, e_wrong, e_miss;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_rej = 0; deadline = 0;
    e_tgt = 8'h00; e_hc = 8'h00; e_mc = 8'h00;
    e_tv = 1'b0; e_hit = 1'b0; e_wrong = 1'b0; e_miss = 1'b0;
  endtask

  task automatic take(input logic [7:0] v);
    e_tgt = v; e_tv = 1'b1; m_phase = 2; m_rej = 0;
    deadline = cyc + TMO;
  endtask

  task automatic model_step(input logic st, input logic sp, input logic [7:0] g,
                            input logic gv, input logic [7:0] c);
    cyc++;
    e_hit = 1'b0; e_wrong = 1'b0; e_miss = 1'b0;
    if (sp) begin
      m_phase = 0; e_tv = 1'b0; m_rej = 0;
    end else if (m_phase == 0) begin
      if (st) begin e_hc = 8'h00; e_mc = 8'h00; m_phase = 1; m_rej = 0; end
    end else if (m_phase == 1) begin
      if (c != 8'h00 && c != e_tgt) take(c);
      else if (m_rej + 1 >= TRIES) take(8'((int'(e_tgt) % 255) + 1));
      else m_rej++;
    end else begin
      if (gv && g == e_tgt) begin
        e_hit = 1'b1; if (e_hc != 8'hFF) e_hc = e_hc + 8'd1;
        e_tv = 1'b0; m_phase = 1;
      end else begin
        if (gv) e_wrong = 1'b1;
        if (cyc == deadline) begin
          e_miss = 1'b1; if (e_mc != 8'hFF) e_mc = e_mc + 8'd1;
          e_tv = 1'b0; m_phase = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".target"}, target, e_tgt);
    chk({ph, ".tv"},     8'(target_valid), 8'(e_tv));
    chk({ph, ".hit"},    8'(hit_pulse), 8'(e_hit));
    chk({ph, ".wrong"},  8'(wrong_pulse), 8'(e_wrong));
    chk({ph, ".miss"},   8'(miss_pulse), 8'(e_miss));
    chk({ph, ".hcnt"},   hit_count, e_hc);
    chk({ph, ".mcnt"},   miss_count, e_mc);
  endtask

  task automatic cycle(input string ph, input logic st, input logic sp, input logic [7:0] g,
                       input logic gv, input logic [15:0] r);
    start = st; stop = sp; guess = g; guess_valid = gv; rnd = r;
    @(posedge clk); #1;
    model_step(st, sp, g, gv, r[7:0]);
    check_all(ph);
  endtask

  initial begin
    int n;
    logic [7:0] hc_before, mc_before;
    rst = 1'b1; start = 1'b0; stop = 1'b0; guess = 8'h00; guess_valid = 1'b0; rnd = 16'h0000;
    cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Start then rnd=0x3C: valid target two edges after start.
    cycle("start", 1'b1, 1'b0, 8'h00, 1'b0, 16'hA500);
    chk("start_tv_low", 8'(target_valid), 8'h00);
    cycle("draw3c", 1'b0, 1'b0, 8'h00, 1'b0, 16'h773C);
    chk("tgt_3c", target, 8'h3C);
    chk("tv_3c", 8'(target_valid), 8'h01);

    // Hit, then 0x3C rejected twice before 0x55 accepted.
    cycle("hit3c", 1'b0, 1'b0, 8'h3C, 1'b1, 16'h0000);
    chk("hit_3c", 8'(hit_pulse), 8'h01);
    chk("hcnt_1", hit_count, 8'h01);
    cycle("rej1", 1'b0, 1'b0, 8'h00, 1'b0, 16'h003C);
    cycle("rej2", 1'b0, 1'b0, 8'h00, 1'b0, 16'h123C);
    chk("rej_tv", 8'(target_valid), 8'h00);
    cycle("acc55", 1'b0, 1'b0, 8'h00, 1'b0, 16'h0055);

    // One wrong guess, then idle until timeout.
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle("tmo", 1'b0, 1'b0, (i == 1) ? 8'h11 : 8'h00, i == 1, 16'h0000);
      if (i == 1) chk("wrong_once", 8'(wrong_pulse), 8'h01);
      if (miss_pulse) begin n = i; break; end
    end
    chk("miss_latency", 8'(n), 8'(TMO));
    chk("mcnt_1", miss_count, 8'h01);

    // Fallback wrap: last target 0xFF, rnd stuck at 0.
    cycle("accff", 1'b0, 1'b0, 8'h00, 1'b0, 16'h00FF);
    cycle("hitff", 1'b0, 1'b0, 8'hFF, 1'b1, 16'h0000);
    for (int i = 0; i < 3; i++) cycle("rej0", 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
    chk("fb_tv_low", 8'(target_valid), 8'h00);
    cycle("fb", 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
    chk("fb_tgt", target, 8'h01);
    chk("fb_tv", 8'(target_valid), 8'h01);

    // Correct guess exactly on the expiry cycle.
    for (int i = 0; i < TMO - 1; i++) cycle("wait", 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
    cycle("hit_exp", 1'b0, 1'b0, 8'h01, 1'b1, 16'h0000);
    chk("exp_hit", 8'(hit_pulse), 8'h01);
    chk("exp_nomiss", 8'(miss_pulse), 8'h00);

    // stop together with a correct guess.
    cycle("acc22", 1'b0, 1'b0, 8'h00, 1'b0, 16'h0022);
    hc_before = hit_count; mc_before = miss_count;
    cycle("stophit", 1'b0, 1'b1, 8'h22, 1'b1, 16'h0000);
    chk("stop_nohit", 8'(hit_pulse), 8'h00);
    chk("stop_tv", 8'(target_valid), 8'h00);
    chk("stop_tgt", target, 8'h22);
    chk("stop_hcnt", hit_count, hc_before);
    chk("stop_mcnt", miss_count, mc_before);
    cycle("stopstart", 1'b1, 1'b1, 8'h00, 1'b0, 16'h0000);
    cycle("idle44", 1'b0, 1'b0, 8'h00, 1'b0, 16'h0044);
    chk("idle_tv", 8'(target_valid), 8'h00);
    cycle("idleguess", 1'b0, 1'b0, 8'h22, 1'b1, 16'h0000);
    chk("idle_nowrong", 8'(wrong_pulse), 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] r;
      logic [7:0]  g;
      int          sel;
      r   = 16'($urandom);
      sel = int'($urandom_range(0, 7));
      if (sel == 0) r[7:0] = 8'h00;
      else if (sel == 1) r[7:0] = e_tgt;
      g = ($urandom_range(0, 1) == 1) ? e_tgt : 8'($urandom);
      cycle("rand", $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0, g,
            $urandom_range(0, 2) == 0, r);
    end

    // Saturation of hit_count over 260 hits.
    cycle("stop2", 1'b0, 1'b1, 8'h00, 1'b0, 16'h0000);
    cycle("start2", 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
    chk("start_clr", hit_count, 8'h00);
    for (int i = 0; i < 260; i++) begin
      cycle("satacc", 1'b0, 1'b0, 8'h00, 1'b0, {8'h00, 8'((int'(e_tgt) % 255) + 1)});
      cycle("sathit", 1'b0, 1'b0, e_tgt, 1'b1, 16'h0000);
    end
    chk("hcnt_sat", hit_count, 8'hFF);

    // Asynchronous reset in the middle of an active round.
    cycle("acc5a", 1'b0, 1'b0, 8'h00, 1'b0, 16'h005A);
    guess = 8'h5A; guess_valid = 1'b1;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk); #1;
    check_all("rst_hold");
    rst = 1'b0;
    cycle("post_rst", 1'b0, 1'b0, 8'h5A, 1'b1, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
